// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyprog_pkg.sv
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__dlyprog_pkg
//  Brief    : Shared state type and select-clamp helper for the programmable delay line.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package gf180mcu_fd_sc_mcu9t5v0__dlyprog_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned depth);
        return (sel > depth - 1) ? depth - 1 : sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyprog_tap.sv
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__dlyprog_tap
//  Brief    : One-bit shift line with a tap mux; the parent's output register is the final stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__dlyprog_tap #(
    parameter int DEPTH = 16,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic             tap
);

    logic [DEPTH-2:0] r_line;
    logic [DEPTH-1:0] w_taps;

    // Tap 0 is the live input so that a select of 0 yields one cycle of delay
    // once the parent registers it.
    assign w_taps = {r_line, din};
    assign tap    = w_taps[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else begin
            r_line <= w_taps[DEPTH-2:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyprog.sv
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__dlyprog
//  Brief    : Multi-channel programmable delay (1..DEPTH cycles) with settle/busy handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__dlyprog
    import gf180mcu_fd_sc_mcu9t5v0__dlyprog_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 16,
    parameter int RST_SEL = 0
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic [WIDTH-1:0]         I,
    input  logic [$clog2(DEPTH)-1:0] SEL,
    input  logic                     LD,
    output logic [WIDTH-1:0]         Z,
    output logic                     BUSY,
    inout  wire                      VDD,
    inout  wire                      VSS
);

    localparam int c_sel_w = $clog2(DEPTH);
    localparam logic [c_sel_w-1:0] c_rst_asel =
        c_sel_w'(clamp_sel(unsigned'(RST_SEL), unsigned'(DEPTH)));

    state_t             r_state;
    logic [c_sel_w-1:0] r_asel;
    logic [c_sel_w-1:0] r_cnt;
    logic               r_busy;
    logic [WIDTH-1:0]   r_z;
    logic [WIDTH-1:0]   w_tap;
    logic [c_sel_w-1:0] w_sel_clamped;
    logic               w_update_z;
    wire                unused_supply;

    assign unused_supply = VDD ^ VSS;

    assign w_sel_clamped = c_sel_w'(clamp_sel(32'(SEL), unsigned'(DEPTH)));

    // Z only follows the line when the next cycle is a RUN cycle, so a load
    // freezes it immediately and the settle exit shows the new delay at once.
    assign w_update_z = !LD && ((r_state == ST_RUN) || (r_cnt == '0));

    generate
        for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
            gf180mcu_fd_sc_mcu9t5v0__dlyprog_tap #(
                .DEPTH (DEPTH),
                .SEL_W (c_sel_w)
            ) u_tap (
                .clk   (CLK),
                .rst_n (RN),
                .din   (I[ch]),
                .sel   (r_asel),
                .tap   (w_tap[ch])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_RUN;
            r_asel  <= c_rst_asel;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_z     <= '0;
        end else begin
            if (LD) begin
                r_asel  <= w_sel_clamped;
                r_cnt   <= w_sel_clamped;
                r_state <= ST_SETTLE;
                r_busy  <= 1'b1;
            end else if (r_state == ST_SETTLE) begin
                if (r_cnt == '0) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - c_sel_w'(1);
                end
            end
            if (w_update_z) begin
                r_z <= w_tap;
            end
        end
    end

    assign Z    = r_z;
    assign BUSY = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyprog.sv
// ============================================================================
//  Module   : tb_gf180mcu_fd_sc_mcu9t5v0__dlyprog
//  Brief    : Self-checking bench: two configurations against a history-based delay model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__dlyprog;

    logic       clk = 1'b0;
    logic       rn  = 1'b0;
    logic       i_a = 1'b0;
    logic [3:0] i_b = '0;
    logic [3:0] sel_a = '0;
    logic [3:0] sel_b = '0;
    logic       ld_a = 1'b0;
    logic       ld_b = 1'b0;
    logic       z_a, busy_a, busy_b;
    logic [3:0] z_b;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__dlyprog #(.WIDTH(1), .DEPTH(16), .RST_SEL(0)) dut_a (
        .CLK(clk), .RN(rn), .I(i_a), .SEL(sel_a), .LD(ld_a),
        .Z(z_a), .BUSY(busy_a), .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__dlyprog #(.WIDTH(4), .DEPTH(12), .RST_SEL(13)) dut_b (
        .CLK(clk), .RN(rn), .I(i_b), .SEL(sel_b), .LD(ld_b),
        .Z(z_b), .BUSY(busy_b), .VDD(vdd), .VSS(vss)
    );

    // Model: per-channel input history; Z is the input sampled D edges back,
    // and a load starts a countdown of (clamped SEL + 1) busy cycles.
    int         m_asel [2];
    int         m_left [2];
    logic [3:0] m_z    [2];
    logic [3:0] hist   [2][64];
    int         m_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         chk_en  = 1'b0;

    function automatic int max_sel(input int k);
        return (k == 0) ? 15 : 11;
    endfunction

    function automatic int clampm(input int k, input int s);
        return (s > max_sel(k)) ? max_sel(k) : s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_asel[k] = clampm(k, (k == 0) ? 0 : 13);
            m_left[k] = 0;
            m_z[k]    = '0;
            for (int j = 0; j < 64; j++) hist[k][j] = '0;
        end
        m_e = 0;
    endtask

    task automatic model_edge();
        logic [3:0] inp [2];
        int         sel [2];
        bit         ld  [2];
        inp[0] = {3'b000, i_a}; sel[0] = int'(sel_a); ld[0] = ld_a;
        inp[1] = i_b;           sel[1] = int'(sel_b); ld[1] = ld_b;
        for (int k = 0; k < 2; k++) begin
            hist[k][m_e % 64] = inp[k];
            if (ld[k]) begin
                m_asel[k] = clampm(k, sel[k]);
                m_left[k] = m_asel[k] + 1;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) m_z[k] = hist[k][(m_e - m_asel[k] + 64) % 64];
            end else begin
                m_z[k] = hist[k][(m_e - m_asel[k] + 64) % 64];
            end
        end
        m_e++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_z_a",    32'(z_a),    32'(m_z[0][0]));
            check("model_busy_a", 32'(busy_a), 32'(m_left[0] > 0));
            check("model_z_b",    32'(z_b),    32'(m_z[1]));
            check("model_busy_b", 32'(busy_b), 32'(m_left[1] > 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] cur_z(input int k);
        return (k == 0) ? {3'b000, z_a} : z_b;
    endfunction

    function automatic logic cur_busy(input int k);
        return (k == 0) ? busy_a : busy_b;
    endfunction

    // Single-cycle pulse, then count cycles until it shows on Z.
    task automatic meas(input int k, input logic [3:0] pat, output int d, output logic [3:0] seen);
        if (k == 0) i_a = pat[0]; else i_b = pat;
        cyc();
        i_a = 1'b0; i_b = '0;
        d = 1;
        while (cur_z(k) == '0 && d < 60) begin
            cyc();
            d++;
        end
        seen = cur_z(k);
    endtask

    task automatic load(input int k, input logic [3:0] s);
        if (k == 0) begin sel_a = s; ld_a = 1'b1; end
        else        begin sel_b = s; ld_b = 1'b1; end
        cyc();
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    task automatic busy_len(input int k, output int n);
        n = 0;
        while (cur_busy(k) && n < 60) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin
        int d, n, na, nb;
        logic [3:0] seen;

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rn = 1'b1;
        chk_en = 1'b1;
        check("rst_z_a", 32'(z_a), 0);
        check("rst_busy_b", 32'(busy_b), 0);

        // Default delay 1 on A; B comes up with RST_SEL 13 clamped to delay 12.
        repeat (4) cyc();
        i_a = 1'b1; i_b = 4'hF;
        cyc();
        i_a = 1'b0; i_b = '0;
        check("dflt_z_a_hi", 32'(z_a), 1);
        check("dflt_busy_a", 32'(busy_a), 0);
        cyc();
        check("dflt_z_a_lo", 32'(z_a), 0);
        repeat (9) cyc();
        check("rst_sel_b_early", 32'(z_b), 0);
        cyc();
        check("rst_sel_b_hit", 32'(z_b), 32'hF);
        cyc();

        // Load SEL=7 while Z is high: Z frozen for 8 busy cycles, then delay 8.
        i_a = 1'b1;
        repeat (3) cyc();
        i_a = 1'b0;
        load(0, 4'd7);
        n = 0;
        while (busy_a && n < 60) begin
            check("ld7_frozen", 32'(z_a), 1);
            n++;
            cyc();
        end
        check("ld7_busy_len", 32'(n), 8);
        check("ld7_run_z", 32'(z_a), 0);
        meas(0, 4'h1, d, seen);
        check("ld7_delay", 32'(d), 8);

        // Clamp: A SEL=15 (no clamp), B SEL=13 -> 11.
        sel_a = 4'hF; sel_b = 4'd13; ld_a = 1'b1; ld_b = 1'b1;
        cyc();
        ld_a = 1'b0; ld_b = 1'b0;
        na = 0; nb = 0; n = 0;
        while ((busy_a || busy_b) && n < 60) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            n++;
            cyc();
        end
        check("clamp_busy_a", 32'(na), 16);
        check("clamp_busy_b", 32'(nb), 12);
        meas(0, 4'h1, d, seen);
        check("clamp_delay_a", 32'(d), 16);
        meas(1, 4'b0110, d, seen);
        check("clamp_delay_b", 32'(d), 12);
        check("clamp_pat_b", 32'(seen), 32'b0110);

        // Reload mid-settle: SEL=9, then SEL=2 three cycles later.
        load(0, 4'd9);
        repeat (2) cyc();
        load(0, 4'd2);
        busy_len(0, n);
        check("reload_busy_len", 32'(n), 3);
        meas(0, 4'h1, d, seen);
        check("reload_delay", 32'(d), 3);

        // Reset in the middle of a settle with Z high.
        i_a = 1'b1; i_b = 4'hF;
        repeat (14) cyc();
        sel_a = 4'd5; sel_b = 4'd10; ld_a = 1'b1; ld_b = 1'b1;
        cyc();
        ld_a = 1'b0; ld_b = 1'b0;
        cyc();
        check("pre_rst_busy_a", 32'(busy_a), 1);
        rn = 1'b0;
        model_reset();
        #1;
        check("midrst_z_a", 32'(z_a), 0);
        check("midrst_busy_a", 32'(busy_a), 0);
        check("midrst_z_b", 32'(z_b), 0);
        check("midrst_busy_b", 32'(busy_b), 0);
        i_a = 1'b0; i_b = '0;
        @(negedge clk);
        #1;
        rn = 1'b1;
        meas(0, 4'h1, d, seen);
        check("midrst_delay_a", 32'(d), 1);
        meas(1, 4'b1001, d, seen);
        check("midrst_delay_b", 32'(d), 12);

        // Load honoured in the first cycle after reset release.
        rn = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        rn = 1'b1;
        load(0, 4'd4);
        check("first_ld_busy", 32'(busy_a), 1);
        busy_len(0, n);
        check("first_ld_busy_len", 32'(n), 5);
        meas(0, 4'h1, d, seen);
        check("first_ld_delay", 32'(d), 5);

        // WIDTH=4 toggling patterns at delay 3: Z(n) = I(n-3) = I(n-1).
        load(1, 4'd2);
        busy_len(1, n);
        check("w4_busy_len", 32'(n), 3);
        i_b = 4'b1010;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (t >= 4) check("w4_toggle", 32'(z_b), 32'(i_b));
            i_b = ~i_b;
        end
        i_b = '0;

        // Randomised traffic checked against the model every cycle.
        for (int t = 0; t < 500; t++) begin
            i_a   = 1'($urandom);
            i_b   = 4'($urandom);
            sel_a = 4'($urandom);
            sel_b = 4'($urandom);
            ld_a  = ($urandom_range(0, 7) == 0);
            ld_b  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        ld_a = 1'b0; ld_b = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
